// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared widths, tag sentinels and bus slice helpers
package reorder_buffer_pkg;
  localparam int WORD_SIZE = 32;
  localparam int RB_SIZE = 8;
  localparam int RB_INDEX = 4;
  localparam int FU_NUM = 4;
  localparam int REG_INDEX = 5;
  localparam logic [RB_INDEX-1:0] READY = '1;
  localparam logic [RB_INDEX-1:0] NULL = READY - 1'b1;
  function automatic logic [WORD_SIZE-1:0] readDataBus(input logic [FU_NUM*WORD_SIZE-1:0] bus, input int i);
    return bus[i*WORD_SIZE +: WORD_SIZE];
  endfunction
  function automatic logic readValidBus(input logic [FU_NUM-1:0] bus, input int i);
    return bus[i];
  endfunction
endpackage

// File: rtl/reorder_buffer_wb_match.sv
// rb_wb_match: per-entry writeback match across FUs, lowest FU index wins
module rb_wb_match
  import reorder_buffer_pkg::*;
(
  input  logic [FU_NUM*WORD_SIZE-1:0]  data_bus,
  input  logic [FU_NUM-1:0]            valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]   tag_bus,
  input  logic [RB_SIZE-1:0]           open,
  output logic [RB_SIZE-1:0]           hit,
  output logic [RB_SIZE*WORD_SIZE-1:0] wb_data
);
  always_comb begin
    hit = '0;
    wb_data = '0;
    // Walk FUs high to low so the lowest-numbered match is written last
    for (int e = 0; e < RB_SIZE; e++)
      for (int i = FU_NUM - 1; i >= 0; i--)
        if (open[e] && readValidBus(valid_bus, i) && tag_bus[i*RB_INDEX +: RB_INDEX] == RB_INDEX'(e)) begin
          hit[e] = 1'b1;
          wb_data[e*WORD_SIZE +: WORD_SIZE] = readDataBus(data_bus, i);
        end
  end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB that tags issued instructions, captures FU results,
// broadcasts done values and retires in order, flushing on a taken branch.
module reorder_buffer #(
  parameter int WORD_SIZE = reorder_buffer_pkg::WORD_SIZE,
  parameter int RB_SIZE = reorder_buffer_pkg::RB_SIZE,
  parameter int RB_INDEX = reorder_buffer_pkg::RB_INDEX,
  parameter int FU_NUM = reorder_buffer_pkg::FU_NUM,
  parameter int REG_INDEX = reorder_buffer_pkg::REG_INDEX
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_valid,
  input  logic [REG_INDEX-1:0]          alloc_dest_reg,
  input  logic                          alloc_is_branch,
  output logic                          alloc_ready,
  output logic [RB_INDEX-1:0]           alloc_index,
  input  logic [FU_NUM*WORD_SIZE-1:0]   data_bus,
  input  logic [FU_NUM-1:0]             valid_bus,
  input  logic [FU_NUM*RB_INDEX-1:0]    RB_index_bus,
  output logic [WORD_SIZE*RB_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic                          commit_valid,
  output logic [REG_INDEX-1:0]          commit_reg,
  output logic [WORD_SIZE-1:0]          commit_data,
  output logic [RB_INDEX-1:0]           commit_index,
  output logic                          flush,
  output logic [FU_NUM-1:0]             reset_bus,
  output logic [RB_INDEX-1:0]           count
);
  localparam int PW = $clog2(RB_SIZE);
  logic [RB_SIZE-1:0] busy_q, busy_d, done_q, done_d, br_q, br_d, open, hit;
  logic [REG_INDEX-1:0] reg_q [RB_SIZE];
  logic [REG_INDEX-1:0] reg_d [RB_SIZE];
  logic [WORD_SIZE-1:0] val_q [RB_SIZE];
  logic [WORD_SIZE-1:0] val_d [RB_SIZE];
  logic [RB_SIZE*WORD_SIZE-1:0] wb_data;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [RB_INDEX-1:0] count_q, count_d, commit_index_q, commit_index_d;
  logic [REG_INDEX-1:0] commit_reg_q, commit_reg_d;
  logic [WORD_SIZE-1:0] commit_data_q, commit_data_d;
  logic commit_valid_q, commit_valid_d, flush_q, flush_d;
  logic do_alloc, do_commit, taken;
  // Writebacks are dropped during the flush cycle
  assign open = busy_q & ~done_q & {RB_SIZE{~flush_q}};
  rb_wb_match u_match (
    .data_bus  (data_bus),
    .valid_bus (valid_bus),
    .tag_bus   (RB_index_bus),
    .open      (open),
    .hit       (hit),
    .wb_data   (wb_data)
  );
  always_comb begin
    alloc_ready = (count_q != RB_INDEX'(RB_SIZE)) && !flush_q;
    do_alloc = alloc_valid && alloc_ready;
    do_commit = busy_q[head_q] && done_q[head_q];
    taken = do_commit && br_q[head_q] && val_q[head_q][0];
    busy_d = busy_q;
    done_d = done_q;
    br_d = br_q;
    reg_d = reg_q;
    val_d = val_q;
    for (int e = 0; e < RB_SIZE; e++)
      if (hit[e]) begin
        done_d[e] = 1'b1;
        val_d[e] = wb_data[e*WORD_SIZE +: WORD_SIZE];
      end
    if (do_alloc) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      br_d[tail_q] = alloc_is_branch;
      reg_d[tail_q] = alloc_dest_reg;
      val_d[tail_q] = '0;
    end
    if (do_commit) busy_d[head_q] = 1'b0;
    head_d = head_q + PW'(do_commit);
    tail_d = tail_q + PW'(do_alloc);
    count_d = count_q + RB_INDEX'(do_alloc) - RB_INDEX'(do_commit);
    commit_valid_d = do_commit;
    commit_reg_d = do_commit ? reg_q[head_q] : commit_reg_q;
    commit_data_d = do_commit ? val_q[head_q] : commit_data_q;
    commit_index_d = do_commit ? RB_INDEX'(head_q) : commit_index_q;
    flush_d = taken;
    if (taken) begin
      busy_d = '0;
      done_d = '0;
      br_d = '0;
      for (int e = 0; e < RB_SIZE; e++) begin
        reg_d[e] = '0;
        val_d[e] = '0;
      end
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busy_q <= '0;
      done_q <= '0;
      br_q <= '0;
      for (int e = 0; e < RB_SIZE; e++) begin
        reg_q[e] <= '0;
        val_q[e] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      commit_valid_q <= 1'b0;
      commit_reg_q <= '0;
      commit_data_q <= '0;
      commit_index_q <= '0;
      flush_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      br_q <= br_d;
      reg_q <= reg_d;
      val_q <= val_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_reg_q <= commit_reg_d;
      commit_data_q <= commit_data_d;
      commit_index_q <= commit_index_d;
      flush_q <= flush_d;
    end
  always_comb begin
    for (int e = 0; e < RB_SIZE; e++) CDB_data_data[e*WORD_SIZE +: WORD_SIZE] = val_q[e];
    CDB_data_valid = busy_q & done_q;
    alloc_index = RB_INDEX'(tail_q);
    commit_valid = commit_valid_q;
    commit_reg = commit_reg_q;
    commit_data = commit_data_q;
    commit_index = commit_index_q;
    flush = flush_q;
    reset_bus = {FU_NUM{flush_q}};
    count = count_q;
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed plus random stimulus against a queue-based program-order model
module tb_reorder_buffer;
  logic clk = 0, reset = 1;
  logic a_valid = 0, a_br = 0;
  logic [4:0] a_dest = 0;
  logic [127:0] dbus = 0;
  logic [3:0] vbus = 0;
  logic [15:0] tbus = 0;
  logic alloc_ready, commit_valid, flush;
  logic [3:0] alloc_index, commit_index, reset_bus, count;
  logic [255:0] CDB_data_data;
  logic [7:0] CDB_data_valid;
  logic [4:0] commit_reg;
  logic [31:0] commit_data;
  int total = 0, bad = 0;

  reorder_buffer dut (
    .clk(clk), .reset(reset), .alloc_valid(a_valid), .alloc_dest_reg(a_dest),
    .alloc_is_branch(a_br), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .data_bus(dbus), .valid_bus(vbus), .RB_index_bus(tbus),
    .CDB_data_data(CDB_data_data), .CDB_data_valid(CDB_data_valid),
    .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_data(commit_data),
    .commit_index(commit_index), .flush(flush), .reset_bus(reset_bus), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    logic [4:0] dest;
    logic br;
    logic done;
    logic [31:0] val;
  } ent_t;
  ent_t q[$];
  int m_tail;
  logic m_flush, e_cv;
  logic [4:0] e_creg;
  logic [31:0] e_cdata;
  int e_cidx;

  task automatic chk(string n, logic [255:0] a, logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    m_flush = 0;
    e_cv = 0;
  endtask

  task automatic model_step();
    logic rdy, taken;
    ent_t ne;
    rdy = q.size() < 8 && !m_flush;
    taken = 0;
    e_cv = 0;
    if (q.size() > 0 && q[0].done) begin
      e_cv = 1;
      e_creg = q[0].dest;
      e_cdata = q[0].val;
      e_cidx = q[0].tag;
      taken = q[0].br && q[0].val[0];
      void'(q.pop_front());
    end
    if (!m_flush)
      for (int i = 0; i < 4; i++)
        if (vbus[i])
          foreach (q[k])
            if (q[k].tag == int'(tbus[i*4 +: 4]) && !q[k].done) begin
              q[k].done = 1;
              q[k].val = dbus[i*32 +: 32];
            end
    if (taken) begin
      q.delete();
      m_tail = 0;
    end else if (a_valid && rdy) begin
      ne.tag = m_tail; ne.dest = a_dest; ne.br = a_br; ne.done = 0; ne.val = 0;
      q.push_back(ne);
      m_tail = (m_tail + 1) % 8;
    end
    m_flush = taken;
  endtask

  task automatic compare();
    logic [7:0] ev;
    ev = 0;
    foreach (q[k]) if (q[k].done) ev[q[k].tag] = 1;
    chk("alloc_ready", alloc_ready, q.size() < 8 && !m_flush);
    chk("alloc_index", alloc_index, m_tail);
    chk("count", count, q.size());
    chk("cdb_valid", CDB_data_valid, ev);
    foreach (q[k]) if (q[k].done) chk("cdb_data", CDB_data_data[q[k].tag*32 +: 32], q[k].val);
    chk("commit_valid", commit_valid, e_cv);
    if (e_cv) begin
      chk("commit_reg", commit_reg, e_creg);
      chk("commit_data", commit_data, e_cdata);
      chk("commit_index", commit_index, e_cidx);
    end
    chk("flush", flush, m_flush);
    chk("reset_bus", reset_bus, {4{m_flush}});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1 compare();
  endtask

  task automatic idle();
    a_valid = 0; a_br = 0; a_dest = 0; vbus = 0; tbus = 0; dbus = 0;
  endtask

  task automatic set_wb(int i, logic [3:0] t, logic [31:0] v);
    vbus[i] = 1;
    tbus[i*4 +: 4] = t;
    dbus[i*32 +: 32] = v;
  endtask

  task automatic alloc1(logic [4:0] d, logic b);
    a_valid = 1; a_dest = d; a_br = b;
    cycle();
    idle();
  endtask

  task automatic reset_lits();
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_index", alloc_index, 0);
    chk("rst_cdb_valid", CDB_data_valid, 0);
    chk("rst_cdb_data", CDB_data_data, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_reg", commit_reg, 0);
    chk("rst_commit_data", commit_data, 0);
    chk("rst_commit_index", commit_index, 0);
    chk("rst_flush", flush, 0);
    chk("rst_reset_bus", reset_bus, 0);
    chk("rst_count", count, 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    model_reset();
    #1 reset_lits();
    @(posedge clk);
    #1 reset = 0;
    compare();
  endtask

  initial begin
    do_reset();
    // in-order retire after out-of-order completion
    chk("t1_idx0", alloc_index, 0); alloc1(1, 0);
    chk("t1_idx1", alloc_index, 1); alloc1(2, 0);
    chk("t1_idx2", alloc_index, 2); alloc1(3, 0);
    chk("t1_count", count, 3);
    set_wb(0, 1, 7); cycle(); idle();
    chk("t1_cdb_tag1", CDB_data_valid, 8'b0000_0010);
    chk("t1_no_commit", commit_valid, 0);
    set_wb(1, 0, 5); cycle(); idle();
    cycle();
    chk("t1_c1_valid", commit_valid, 1); chk("t1_c1_reg", commit_reg, 1); chk("t1_c1_data", commit_data, 5);
    cycle();
    chk("t1_c2_valid", commit_valid, 1); chk("t1_c2_reg", commit_reg, 2); chk("t1_c2_data", commit_data, 7);
    cycle();
    // full buffer: commit edge does not free a slot for the same-edge allocation
    do_reset();
    for (int k = 1; k <= 8; k++) alloc1(5'(k), 0);
    chk("t2_full_ready", alloc_ready, 0);
    chk("t2_full_count", count, 8);
    a_valid = 1; a_dest = 9;
    set_wb(0, 0, 42); cycle(); vbus = 0;
    cycle();
    chk("t2_commit", commit_valid, 1);
    chk("t2_count", count, 7);
    chk("t2_ready", alloc_ready, 1);
    chk("t2_wrap_idx", alloc_index, 0);
    idle();
    cycle();
    // two FUs on one tag
    do_reset();
    for (int k = 0; k < 4; k++) alloc1(5'(k + 1), 0);
    set_wb(0, 3, 11); set_wb(2, 3, 22); cycle(); idle();
    chk("t3_cdb_valid", CDB_data_valid, 8'b0000_1000);
    chk("t3_prio", CDB_data_data[3*32 +: 32], 11);
    // taken branch flushes
    do_reset();
    alloc1(0, 1);
    alloc1(5, 0);
    set_wb(0, 0, 1); set_wb(1, 1, 9); cycle(); idle();
    a_valid = 1; a_dest = 3;
    cycle();
    chk("t4_commit", commit_valid, 1);
    chk("t4_flush", flush, 1);
    chk("t4_reset_bus", reset_bus, 4'b1111);
    chk("t4_count", count, 0);
    chk("t4_ready", alloc_ready, 0);
    set_wb(0, 1, 4); cycle(); idle();
    chk("t4_flush_end", flush, 0);
    chk("t4_ready_back", alloc_ready, 1);
    chk("t4_no_commit", commit_valid, 0);
    for (int k = 0; k < 3; k++) cycle();
    // not-taken branch
    alloc1(0, 1);
    set_wb(3, 0, 0); cycle(); idle();
    cycle();
    chk("t5_commit", commit_valid, 1);
    chk("t5_no_flush", flush, 0);
    chk("t5_index", commit_index, 0);
    cycle();
    // asynchronous reset mid-operation
    do_reset();
    for (int k = 0; k < 5; k++) alloc1(5'(k + 1), 0);
    set_wb(1, 2, 77);
    #3 reset = 1;
    #1 reset_lits();
    model_reset();
    idle();
    @(posedge clk);
    #1 reset = 0;
    set_wb(0, 2, 99); cycle(); idle();
    chk("t6_ignored", CDB_data_valid, 0);
    chk("t6_count", count, 0);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      a_valid = ($urandom % 10) < 6;
      a_dest = 5'($urandom);
      a_br = ($urandom % 5) == 0;
      vbus = 0;
      for (int i = 0; i < 4; i++)
        if (($urandom % 10) < 4) begin
          r = $urandom % 10;
          set_wb(i, r < 8 ? 4'(r) : (r == 8 ? 4'd14 : 4'd15), $urandom);
        end
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
